// File: rtl/mpsoc_wb_ext_arbiter.sv
// Round-robin Wishbone arbiter merging NODES tile masters onto one slave.
// Grant is held for a whole cyc; a per-access timeout errors a hung slave.
module mpsoc_wb_ext_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int NODES   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NODES-1:0][AW-1:0]  m_adr_i,
  input  logic [NODES-1:0][DW-1:0]  m_dat_i,
  input  logic [NODES-1:0][3:0]     m_sel_i,
  input  logic [NODES-1:0]          m_cyc_i,
  input  logic [NODES-1:0]          m_stb_i,
  input  logic [NODES-1:0]          m_we_i,
  input  logic [NODES-1:0]          m_cab_i,
  input  logic [NODES-1:0][2:0]     m_cti_i,
  input  logic [NODES-1:0][1:0]     m_bte_i,
  output logic [NODES-1:0]          m_ack_o,
  output logic [NODES-1:0]          m_err_o,
  output logic [NODES-1:0]          m_rty_o,
  output logic [NODES-1:0][DW-1:0]  m_dat_o,
  output logic [AW-1:0]             s_adr_o,
  output logic [DW-1:0]             s_dat_o,
  output logic [3:0]                s_sel_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic                      s_cab_o,
  output logic [2:0]                s_cti_o,
  output logic [1:0]                s_bte_o,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  input  logic                      s_rty_i,
  input  logic [DW-1:0]             s_dat_i,
  output logic [NODES-1:0]          grant_o,
  output logic                      timeout_o
);

  localparam int IW = (NODES > 1) ? $clog2(NODES) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);
  localparam logic [IW:0]   N_EXT  = (IW+1)'(NODES);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state;
  logic [IW-1:0]    gnt_idx;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    nxt_idx;
  logic             found;
  logic [IW:0]      cand;
  logic [CW-1:0]    cnt;
  logic [NODES-1:0] grant_q;
  logic             active;
  logic             own_cyc;
  logic             own_stb;
  logic             term;
  logic             to_hit;

  assign active  = (state == ACTIVE);
  assign own_cyc = m_cyc_i[gnt_idx];
  assign own_stb = m_stb_i[gnt_idx];
  assign term    = s_ack_i | s_err_i | s_rty_i;
  // A slave termination in the limit cycle wins over the timeout
  assign to_hit  = active & own_cyc & own_stb
                 & (cnt == TO_LIM) & ~term;

  assign grant_o   = grant_q;
  assign timeout_o = to_hit;
  assign m_dat_o   = {NODES{s_dat_i}};

  // First requester at or after rr_ptr, wrapping upward
  always_comb begin
    nxt_idx = rr_ptr;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < NODES; i++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(i);
      if (cand >= N_EXT) cand = cand - N_EXT;
      if (!found && m_cyc_i[cand[IW-1:0]]) begin
        found   = 1'b1;
        nxt_idx = cand[IW-1:0];
      end
    end
  end

  // Owner request mux toward the slave and response demux back
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_cab_o = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    if (active) begin
      s_adr_o = m_adr_i[gnt_idx];
      s_dat_o = m_dat_i[gnt_idx];
      s_sel_o = m_sel_i[gnt_idx];
      s_cyc_o = own_cyc & ~to_hit;
      s_stb_o = own_stb & ~to_hit;
      s_we_o  = m_we_i[gnt_idx];
      s_cab_o = m_cab_i[gnt_idx];
      s_cti_o = m_cti_i[gnt_idx];
      s_bte_o = m_bte_i[gnt_idx];
      if (own_cyc) begin
        m_ack_o[gnt_idx] = s_ack_i;
        m_err_o[gnt_idx] = s_err_i | to_hit;
        m_rty_o[gnt_idx] = s_rty_i;
      end
    end
  end

  // Arbitration FSM, round-robin pointer and access timeout counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gnt_idx <= '0;
      rr_ptr  <= '0;
      cnt     <= '0;
      grant_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (found) begin
            state            <= ACTIVE;
            gnt_idx          <= nxt_idx;
            grant_q          <= '0;
            grant_q[nxt_idx] <= 1'b1;
          end
        end
        ACTIVE: begin
          if (!own_cyc) begin
            state   <= IDLE;
            grant_q <= '0;
            cnt     <= '0;
            if (gnt_idx == IW'(NODES - 1))
              rr_ptr <= '0;
            else
              rr_ptr <= gnt_idx + IW'(1);
          end else if (term || !own_stb || to_hit) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mpsoc_wb_ext_arbiter.sv
// Bench for mpsoc_wb_ext_arbiter: directed masters, scoreboard monitor.
// Expected grants and responses are queued by stimulus, checked at negedge.
module tb_mpsoc_wb_ext_arbiter;

  localparam int N  = 16;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam logic [DW-1:0] RD = 32'hC0DE_1234;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [N-1:0][AW-1:0]  m_adr_i = '0;
  logic [N-1:0][DW-1:0]  m_dat_i = '0;
  logic [N-1:0][3:0]     m_sel_i = '0;
  logic [N-1:0]          m_cyc_i = '0;
  logic [N-1:0]          m_stb_i = '0;
  logic [N-1:0]          m_we_i  = '0;
  logic [N-1:0]          m_cab_i = '0;
  logic [N-1:0][2:0]     m_cti_i = '0;
  logic [N-1:0][1:0]     m_bte_i = '0;
  logic [N-1:0]          m_ack_o;
  logic [N-1:0]          m_err_o;
  logic [N-1:0]          m_rty_o;
  logic [N-1:0][DW-1:0]  m_dat_o;
  logic [AW-1:0]         s_adr_o;
  logic [DW-1:0]         s_dat_o;
  logic [3:0]            s_sel_o;
  logic                  s_cyc_o;
  logic                  s_stb_o;
  logic                  s_we_o;
  logic                  s_cab_o;
  logic [2:0]            s_cti_o;
  logic [1:0]            s_bte_o;
  logic                  s_ack_i;
  logic                  s_err_i = 1'b0;
  logic                  s_rty_i = 1'b0;
  logic [DW-1:0]         s_dat_i = RD;
  logic [N-1:0]          grant_o;
  logic                  timeout_o;

  logic slv_en    = 1'b0;
  logic force_ack = 1'b0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  typedef struct {
    int          idx;
    bit          err;
    bit          to;
    int          cti;
    logic [31:0] adr;
    bit          we;
  } ev_t;

  typedef struct {
    int idx;
    int gap;
  } gnt_t;

  ev_t  ev_q[$];
  gnt_t gq[$];

  always #5 clk = ~clk;

  // Zero-wait slave keyed off the registered grant (no comb loop)
  assign s_ack_i = (slv_en & |(grant_o & m_cyc_i & m_stb_i))
                 | force_ack;

  mpsoc_wb_ext_arbiter #(
    .AW(AW), .DW(DW), .NODES(N), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_cab_i(m_cab_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .m_dat_o(m_dat_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_cab_o(s_cab_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .s_dat_i(s_dat_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [31:0] base(input int idx);
    return 32'hA000_0000 + 32'(idx) * 32'h100;
  endfunction

  function automatic void push_x(input int idx, input int beats,
                                 input bit burst);
    for (int b = 0; b < beats; b++) begin
      ev_t e;
      e.idx = idx;
      e.err = 1'b0;
      e.to  = 1'b0;
      e.adr = base(idx) + 32'(b * 4);
      e.we  = idx[0];
      e.cti = burst ? ((b == beats - 1) ? 7 : 2) : 0;
      ev_q.push_back(e);
    end
  endfunction

  function automatic void push_g(input int idx, input int gap);
    gnt_t g;
    g.idx = idx;
    g.gap = gap;
    gq.push_back(g);
  endfunction

  // One master holding cyc for `beats` terminated accesses
  task automatic xfer(input int idx, input int beats, input bit burst);
    int cnt;
    int guard;
    cnt   = 0;
    guard = 0;
    @(posedge clk); #1;
    m_adr_i[idx] = base(idx);
    m_we_i[idx]  = idx[0];
    m_sel_i[idx] = 4'hF;
    m_cti_i[idx] = burst ? ((beats > 1) ? 3'b010 : 3'b111) : 3'b000;
    m_cyc_i[idx] = 1'b1;
    m_stb_i[idx] = 1'b1;
    while (cnt < beats && guard < 100) begin
      @(negedge clk);
      guard++;
      if (m_ack_o[idx] || m_err_o[idx]) cnt++;
      if (cnt < beats) begin
        @(posedge clk); #1;
        m_adr_i[idx] = base(idx) + 32'(cnt * 4);
        if (burst)
          m_cti_i[idx] = (cnt == beats - 1) ? 3'b111 : 3'b010;
      end
    end
    chk($sformatf("xfer_done_m%0d", idx), 64'(guard < 100), 64'd1);
    @(posedge clk); #1;
    m_cyc_i[idx] = 1'b0;
    m_stb_i[idx] = 1'b0;
    m_cti_i[idx] = 3'b000;
  endtask

  task automatic wait_grant(input int idx);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (grant_o[idx]) seen = 1'b1;
    end
    chk($sformatf("grant_seen_m%0d", idx), 64'(seen), 64'd1);
  endtask

  // Scoreboard monitor: grants and terminations sampled at negedge
  initial begin
    logic [N-1:0] prev_g;
    logic [N-1:0] exv;
    int           idle;
    bit           ok;
    ev_t          e;
    gnt_t         g;
    prev_g = '0;
    idle   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_g = '0;
        idle   = 0;
      end else begin
        if (grant_o != prev_g && grant_o != '0) begin
          if (gq.size() == 0) begin
            chk("grant_unexpected", 64'(grant_o), 64'd0);
          end else begin
            g   = gq.pop_front();
            exv = '0;
            exv[g.idx] = 1'b1;
            chk("grant_owner", 64'(grant_o), 64'(exv));
            if (g.gap >= 0)
              chk("grant_idle_gap", 64'(idle), 64'(g.gap));
          end
          idle = 0;
        end else if (grant_o == '0) begin
          idle++;
        end
        prev_g = grant_o;
        if (|m_ack_o || |m_err_o || |m_rty_o || timeout_o) begin
          if (ev_q.size() == 0) begin
            chk("resp_unexpected", {m_ack_o, m_err_o}, 64'd0);
          end else begin
            e   = ev_q.pop_front();
            exv = '0;
            exv[e.idx] = 1'b1;
            chk("resp_ack", 64'(m_ack_o), e.err ? 64'd0 : 64'(exv));
            chk("resp_err", 64'(m_err_o), e.err ? 64'(exv) : 64'd0);
            chk("resp_rty", 64'(m_rty_o), 64'd0);
            chk("resp_timeout", 64'(timeout_o), 64'(e.to));
            chk("resp_adr", 64'(s_adr_o), 64'(e.adr));
            chk("resp_we", 64'(s_we_o), 64'(e.we));
            chk("resp_cti", 64'(s_cti_o), 64'(e.cti));
            ok = 1'b1;
            for (int k = 0; k < N; k++)
              if (m_dat_o[k] !== RD) ok = 1'b0;
            chk("rd_data_bcast", 64'(ok), 64'd1);
          end
        end
      end
    end
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", 64'(grant_o), 64'd0);
    chk("rst_timeout", 64'(timeout_o), 64'd0);
    chk("rst_s_cyc", 64'(s_cyc_o), 64'd0);
    chk("rst_s_stb", 64'(s_stb_o), 64'd0);
    chk("rst_m_ack", 64'(m_ack_o), 64'd0);
    rst    = 1'b0;
    slv_en = 1'b1;

    // Round robin among 0, 5, 9 starting at pointer 0
    push_g(0, -1); push_g(5, 1); push_g(9, 1); push_g(0, 1);
    push_x(0, 1, 0); push_x(5, 1, 0); push_x(9, 1, 0); push_x(0, 1, 0);
    fork
      begin xfer(0, 1, 0); xfer(0, 1, 0); end
      xfer(5, 1, 0);
      xfer(9, 1, 0);
    join
    repeat (3) @(posedge clk);

    // Single master, three accesses in one cyc, latency check
    push_g(3, -1);
    push_x(3, 3, 0);
    fork
      xfer(3, 3, 0);
      begin
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat_req_cycle_cyc", 64'(s_cyc_o), 64'd0);
        chk("lat_req_cycle_gnt", 64'(grant_o), 64'd0);
        @(negedge clk);
        chk("lat_next_cyc", 64'(s_cyc_o), 64'd1);
        chk("lat_next_gnt", 64'(grant_o), 64'h0008);
      end
    join
    repeat (3) @(posedge clk);

    // Burst on master 2 holds grant while master 1 waits
    push_g(2, -1); push_g(1, 1);
    push_x(2, 4, 1); push_x(1, 1, 0);
    fork
      xfer(2, 4, 1);
      begin wait_grant(2); xfer(1, 1, 0); end
    join
    repeat (3) @(posedge clk);

    // Hung slave: error and pulse TO cycles after stb is seen
    slv_en = 1'b0;
    push_g(4, -1);
    begin
      ev_t e;
      e.idx = 4; e.err = 1'b1; e.to = 1'b1;
      e.cti = 0; e.adr = base(4); e.we = 1'b0;
      ev_q.push_back(e);
    end
    fork
      xfer(4, 1, 0);
      begin
        wait_grant(4);
        for (int k = 1; k < TO; k++) begin
          @(negedge clk);
          chk("to_early_err", 64'(m_err_o), 64'd0);
          chk("to_early_stb", 64'(s_stb_o), 64'd1);
        end
        @(negedge clk);
        chk("to_err", 64'(m_err_o), 64'h0010);
        chk("to_pulse", 64'(timeout_o), 64'd1);
        chk("to_stb_low", 64'(s_stb_o), 64'd0);
        chk("to_cyc_low", 64'(s_cyc_o), 64'd0);
      end
    join
    repeat (3) @(posedge clk);

    // Slave ack lands exactly in the limit cycle
    push_g(6, -1);
    push_x(6, 1, 0);
    fork
      xfer(6, 1, 0);
      begin
        wait_grant(6);
        repeat (TO) @(posedge clk);
        #1 force_ack = 1'b1;
        @(negedge clk);
        chk("race_ack", 64'(m_ack_o), 64'h0040);
        chk("race_err", 64'(m_err_o), 64'd0);
        chk("race_pulse", 64'(timeout_o), 64'd0);
        @(posedge clk);
        #1 force_ack = 1'b0;
      end
    join
    repeat (3) @(posedge clk);

    // Reset mid-burst, then pointer back at 0 (0 beats 7)
    push_g(2, -1);
    @(posedge clk); #1;
    m_adr_i[2] = base(2);
    m_sel_i[2] = 4'hF;
    m_cti_i[2] = 3'b010;
    m_cyc_i[2] = 1'b1;
    m_stb_i[2] = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_grant", 64'(grant_o), 64'd0);
    chk("arst_s_cyc", 64'(s_cyc_o), 64'd0);
    chk("arst_s_stb", 64'(s_stb_o), 64'd0);
    chk("arst_s_adr", 64'(s_adr_o), 64'd0);
    chk("arst_m_err", 64'(m_err_o), 64'd0);
    chk("arst_timeout", 64'(timeout_o), 64'd0);
    m_cyc_i[2] = 1'b0;
    m_stb_i[2] = 1'b0;
    m_cti_i[2] = 3'b000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    slv_en = 1'b1;
    push_g(0, -1); push_g(7, 1);
    push_x(0, 1, 0); push_x(7, 1, 0);
    fork
      xfer(0, 1, 0);
      xfer(7, 1, 0);
    join
    repeat (5) @(negedge clk);

    chk("events_drained", 64'(ev_q.size()), 64'd0);
    chk("grants_drained", 64'(gq.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
